// File: rtl/regfile_write_arbiter.sv
// Register-file write-port arbiter.
// Two writeback requesters (ALU on port 0, load unit on port 1) share one
// register-file write port. A round-robin pointer breaks ties. Byte and
// halfword writes become read-modify-write: one merge-read cycle (RD), then
// the write cycle (WR), which keeps the untouched upper bits of the
// destination register. The in-flight destination is exported so decode
// can stall on hazards.
module regfile_write_arbiter #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 5,
    parameter bit ZERO_WIRED = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_data,
    input  logic [1:0]        req0_size,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_data,
    input  logic [1:0]        req1_size,
    output logic              rf_re,
    output logic [ADDR_W-1:0] rf_raddr,
    input  logic [DATA_W-1:0] rf_rdata,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    output logic              wb_busy,
    output logic [ADDR_W-1:0] wb_busy_addr
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2
    } state_t;

    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_BYTE = 2'b10;

    // Halfword and byte writes need the old register contents first.
    function automatic logic is_partial(input logic [1:0] size);
        return (size == SIZE_HALF) || (size == SIZE_BYTE);
    endfunction

    // Register 0 is hard-wired: its writes are accepted but never strobed.
    function automatic logic drop_write(input logic [ADDR_W-1:0] addr);
        return ZERO_WIRED && (addr == {ADDR_W{1'b0}});
    endfunction

    // Mask of bits taken from the old register value for a given size.
    function automatic logic [DATA_W-1:0] keep_mask(input logic [1:0] size);
        logic [DATA_W-1:0] mask;
        case (size)
            SIZE_HALF: mask = ~{{(DATA_W-16){1'b0}}, 16'hFFFF};
            SIZE_BYTE: mask = ~{{(DATA_W-8){1'b0}}, 8'hFF};
            default:   mask = {DATA_W{1'b0}};
        endcase
        return mask;
    endfunction

    state_t            state_r;
    logic              rr_r;
    logic [ADDR_W-1:0] addr_r;
    logic [DATA_W-1:0] data_r;
    logic [1:0]        size_r;

    logic              rf_re_r;
    logic [ADDR_W-1:0] rf_raddr_r;
    logic              rf_we_r;
    logic [ADDR_W-1:0] rf_waddr_r;
    logic              wb_busy_r;
    logic [ADDR_W-1:0] wb_busy_addr_r;

    logic              grant0_s;
    logic              grant1_s;
    logic              accept_s;
    logic [ADDR_W-1:0] new_addr_s;
    logic [DATA_W-1:0] new_data_s;
    logic [1:0]        new_size_s;
    logic [DATA_W-1:0] mask_s;
    logic [DATA_W-1:0] wdata_s;

    // Round-robin grant; a new request can only be taken in IDLE or WR.
    always_comb begin
        grant0_s = 1'b0;
        grant1_s = 1'b0;
        if ((state_r == IDLE) || (state_r == WR)) begin
            if (req0_valid && req1_valid) begin
                grant0_s = ~rr_r;
                grant1_s = rr_r;
            end else begin
                grant0_s = req0_valid;
                grant1_s = req1_valid;
            end
        end else begin
            grant0_s = 1'b0;
            grant1_s = 1'b0;
        end
    end

    assign accept_s   = grant0_s | grant1_s;
    assign req0_ready = grant0_s;
    assign req1_ready = grant1_s;

    // Select the fields of the winning requester.
    always_comb begin
        new_addr_s = req0_addr;
        new_data_s = req0_data;
        new_size_s = req0_size;
        if (grant1_s) begin
            new_addr_s = req1_addr;
            new_data_s = req1_data;
            new_size_s = req1_size;
        end else begin
            new_addr_s = req0_addr;
            new_data_s = req0_data;
            new_size_s = req0_size;
        end
    end

    // Merge the new low bits with the register's old upper bits in WR.
    always_comb begin
        mask_s  = keep_mask(size_r);
        wdata_s = {DATA_W{1'b0}};
        if (state_r == WR) begin
            wdata_s = (rf_rdata & mask_s) | (data_r & ~mask_s);
        end else begin
            wdata_s = {DATA_W{1'b0}};
        end
    end

    assign rf_wdata = wdata_s;

    // Write FSM with latched request and registered strobes/hazard outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r        <= IDLE;
            rr_r           <= 1'b0;
            addr_r         <= {ADDR_W{1'b0}};
            data_r         <= {DATA_W{1'b0}};
            size_r         <= 2'b00;
            rf_re_r        <= 1'b0;
            rf_raddr_r     <= {ADDR_W{1'b0}};
            rf_we_r        <= 1'b0;
            rf_waddr_r     <= {ADDR_W{1'b0}};
            wb_busy_r      <= 1'b0;
            wb_busy_addr_r <= {ADDR_W{1'b0}};
        end else begin
            case (state_r)
                IDLE, WR: begin
                    if (accept_s) begin
                        state_r        <= is_partial(new_size_s) ? RD : WR;
                        rr_r           <= grant0_s;
                        addr_r         <= new_addr_s;
                        data_r         <= new_data_s;
                        size_r         <= new_size_s;
                        rf_re_r        <= is_partial(new_size_s);
                        rf_raddr_r     <= is_partial(new_size_s) ? new_addr_s : {ADDR_W{1'b0}};
                        rf_we_r        <= !is_partial(new_size_s) && !drop_write(new_addr_s);
                        rf_waddr_r     <= is_partial(new_size_s) ? {ADDR_W{1'b0}} : new_addr_s;
                        wb_busy_r      <= 1'b1;
                        wb_busy_addr_r <= new_addr_s;
                    end else begin
                        state_r        <= IDLE;
                        rf_re_r        <= 1'b0;
                        rf_raddr_r     <= {ADDR_W{1'b0}};
                        rf_we_r        <= 1'b0;
                        rf_waddr_r     <= {ADDR_W{1'b0}};
                        wb_busy_r      <= 1'b0;
                        wb_busy_addr_r <= {ADDR_W{1'b0}};
                    end
                end
                RD: begin
                    state_r    <= WR;
                    rf_re_r    <= 1'b0;
                    rf_raddr_r <= {ADDR_W{1'b0}};
                    rf_we_r    <= !drop_write(addr_r);
                    rf_waddr_r <= addr_r;
                end
                default: begin
                    state_r        <= IDLE;
                    rf_re_r        <= 1'b0;
                    rf_raddr_r     <= {ADDR_W{1'b0}};
                    rf_we_r        <= 1'b0;
                    rf_waddr_r     <= {ADDR_W{1'b0}};
                    wb_busy_r      <= 1'b0;
                    wb_busy_addr_r <= {ADDR_W{1'b0}};
                end
            endcase
        end
    end

    assign rf_re        = rf_re_r;
    assign rf_raddr     = rf_raddr_r;
    assign rf_we        = rf_we_r;
    assign rf_waddr     = rf_waddr_r;
    assign wb_busy      = wb_busy_r;
    assign wb_busy_addr = wb_busy_addr_r;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed testbench for regfile_write_arbiter.
module tb_regfile_write_arbiter;

    logic        clk;
    logic        rst_n;
    logic        req0_valid;
    logic        req0_ready;
    logic [4:0]  req0_addr;
    logic [31:0] req0_data;
    logic [1:0]  req0_size;
    logic        req1_valid;
    logic        req1_ready;
    logic [4:0]  req1_addr;
    logic [31:0] req1_data;
    logic [1:0]  req1_size;
    logic        rf_re;
    logic [4:0]  rf_raddr;
    logic [31:0] rf_rdata;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        wb_busy;
    logic [4:0]  wb_busy_addr;

    int errors;
    int checks;

    regfile_write_arbiter #(
        .DATA_W(32),
        .ADDR_W(5),
        .ZERO_WIRED(1'b1)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .req0_valid(req0_valid),
        .req0_ready(req0_ready),
        .req0_addr(req0_addr),
        .req0_data(req0_data),
        .req0_size(req0_size),
        .req1_valid(req1_valid),
        .req1_ready(req1_ready),
        .req1_addr(req1_addr),
        .req1_data(req1_data),
        .req1_size(req1_size),
        .rf_re(rf_re),
        .rf_raddr(rf_raddr),
        .rf_rdata(rf_rdata),
        .rf_we(rf_we),
        .rf_waddr(rf_waddr),
        .rf_wdata(rf_wdata),
        .wb_busy(wb_busy),
        .wb_busy_addr(wb_busy_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        errors     = 0;
        checks     = 0;
        rst_n      = 1'b0;
        req0_valid = 1'b0;
        req0_addr  = 5'd0;
        req0_data  = 32'h0;
        req0_size  = 2'b00;
        req1_valid = 1'b0;
        req1_addr  = 5'd0;
        req1_data  = 32'h0;
        req1_size  = 2'b00;
        rf_rdata   = 32'hFFFF_FFFF;

        // Reset state
        tick();
        tick();
        chk("rst_we", {31'd0, rf_we}, 32'd0);
        chk("rst_re", {31'd0, rf_re}, 32'd0);
        chk("rst_busy", {31'd0, wb_busy}, 32'd0);
        chk("rst_wdata", rf_wdata, 32'h0);
        rst_n = 1'b1;
        tick();

        // req0 word write to r5
        req0_valid = 1'b1; req0_addr = 5'd5; req0_data = 32'hDEAD_BEEF; req0_size = 2'b00;
        #1;
        chk("w_ready0", {31'd0, req0_ready}, 32'd1);
        chk("w_ready1", {31'd0, req1_ready}, 32'd0);
        tick();
        req0_valid = 1'b0;
        chk("w_we", {31'd0, rf_we}, 32'd1);
        chk("w_waddr", {27'd0, rf_waddr}, 32'd5);
        chk("w_wdata", rf_wdata, 32'hDEAD_BEEF);
        chk("w_busy", {31'd0, wb_busy}, 32'd1);
        chk("w_busy_addr", {27'd0, wb_busy_addr}, 32'd5);
        tick();
        chk("w_idle_we", {31'd0, rf_we}, 32'd0);
        chk("w_idle_busy", {31'd0, wb_busy}, 32'd0);

        // req1 byte write to r7 (old 0x11223344)
        req1_valid = 1'b1; req1_addr = 5'd7; req1_data = 32'h0000_00AB; req1_size = 2'b10;
        #1;
        chk("b_ready1", {31'd0, req1_ready}, 32'd1);
        chk("b_ready0", {31'd0, req0_ready}, 32'd0);
        tick();
        req1_valid = 1'b0;
        chk("b_re", {31'd0, rf_re}, 32'd1);
        chk("b_raddr", {27'd0, rf_raddr}, 32'd7);
        chk("b_rd_we", {31'd0, rf_we}, 32'd0);
        chk("b_busy_addr", {27'd0, wb_busy_addr}, 32'd7);
        rf_rdata = 32'h1122_3344;
        tick();
        chk("b_we", {31'd0, rf_we}, 32'd1);
        chk("b_waddr", {27'd0, rf_waddr}, 32'd7);
        chk("b_wdata", rf_wdata, 32'h1122_33AB);
        chk("b_wr_re", {31'd0, rf_re}, 32'd0);
        rf_rdata = 32'hFFFF_FFFF;
        tick();
        chk("b_idle_busy", {31'd0, wb_busy}, 32'd0);

        // req1 halfword write to r7 (old 0x11223344)
        req1_valid = 1'b1; req1_addr = 5'd7; req1_data = 32'h0000_BEEF; req1_size = 2'b01;
        #1;
        chk("h_ready1", {31'd0, req1_ready}, 32'd1);
        tick();
        req1_valid = 1'b0;
        chk("h_re", {31'd0, rf_re}, 32'd1);
        rf_rdata = 32'h1122_3344;
        tick();
        chk("h_we", {31'd0, rf_we}, 32'd1);
        chk("h_wdata", rf_wdata, 32'h1122_BEEF);
        rf_rdata = 32'hFFFF_FFFF;
        tick();

        // Both requesters valid: alternating grants, one ready at a time
        req0_valid = 1'b1; req0_addr = 5'd1; req0_data = 32'h0000_0001; req0_size = 2'b00;
        req1_valid = 1'b1; req1_addr = 5'd2; req1_data = 32'h0000_0002; req1_size = 2'b11;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("rr_ready0", {31'd0, req0_ready}, (i % 2 == 0) ? 32'd1 : 32'd0);
            chk("rr_ready1", {31'd0, req1_ready}, (i % 2 == 1) ? 32'd1 : 32'd0);
            tick();
            chk("rr_we", {31'd0, rf_we}, 32'd1);
            chk("rr_waddr", {27'd0, rf_waddr}, (i % 2 == 0) ? 32'd1 : 32'd2);
            chk("rr_wdata", rf_wdata, (i % 2 == 0) ? 32'd1 : 32'd2);
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        tick();
        chk("rr_idle_we", {31'd0, rf_we}, 32'd0);

        // Word write to r0: handshake completes but no strobe
        req0_valid = 1'b1; req0_addr = 5'd0; req0_data = 32'h1234_5678; req0_size = 2'b00;
        #1;
        chk("z_ready0", {31'd0, req0_ready}, 32'd1);
        tick();
        req0_valid = 1'b0;
        chk("z_we", {31'd0, rf_we}, 32'd0);
        chk("z_busy", {31'd0, wb_busy}, 32'd1);
        chk("z_busy_addr", {27'd0, wb_busy_addr}, 32'd0);
        tick();
        chk("z_busy_end", {31'd0, wb_busy}, 32'd0);
        chk("z_we_end", {31'd0, rf_we}, 32'd0);

        // Three back-to-back words: no bubble
        req0_valid = 1'b1; req0_addr = 5'd10; req0_data = 32'h0000_00A0; req0_size = 2'b00;
        #1;
        chk("bb_ready_a", {31'd0, req0_ready}, 32'd1);
        tick();
        req0_addr = 5'd11; req0_data = 32'h0000_00B0;
        #1;
        chk("bb_we_a", {31'd0, rf_we}, 32'd1);
        chk("bb_waddr_a", {27'd0, rf_waddr}, 32'd10);
        chk("bb_busy_a", {27'd0, wb_busy_addr}, 32'd10);
        chk("bb_ready_b", {31'd0, req0_ready}, 32'd1);
        tick();
        req0_addr = 5'd12; req0_data = 32'h0000_00C0;
        #1;
        chk("bb_we_b", {31'd0, rf_we}, 32'd1);
        chk("bb_waddr_b", {27'd0, rf_waddr}, 32'd11);
        chk("bb_wdata_b", rf_wdata, 32'h0000_00B0);
        chk("bb_busy_b", {27'd0, wb_busy_addr}, 32'd11);
        tick();
        req0_valid = 1'b0;
        chk("bb_we_c", {31'd0, rf_we}, 32'd1);
        chk("bb_waddr_c", {27'd0, rf_waddr}, 32'd12);
        chk("bb_busy_c", {27'd0, wb_busy_addr}, 32'd12);
        tick();
        chk("bb_idle_we", {31'd0, rf_we}, 32'd0);

        // Reset in the middle of RD aborts the write
        req0_valid = 1'b1; req0_addr = 5'd7; req0_data = 32'h0000_5555; req0_size = 2'b01;
        #1;
        chk("ab_ready0", {31'd0, req0_ready}, 32'd1);
        tick();
        req0_valid = 1'b0;
        chk("ab_re", {31'd0, rf_re}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ab_rst_re", {31'd0, rf_re}, 32'd0);
        chk("ab_rst_busy", {31'd0, wb_busy}, 32'd0);
        chk("ab_rst_raddr", {27'd0, rf_raddr}, 32'd0);
        tick();
        chk("ab_rst_we", {31'd0, rf_we}, 32'd0);
        rst_n = 1'b1;
        tick();
        chk("ab_post_we", {31'd0, rf_we}, 32'd0);
        chk("ab_post_busy", {31'd0, wb_busy}, 32'd0);
        req1_valid = 1'b1; req1_addr = 5'd3; req1_data = 32'h0; req1_size = 2'b00;
        req0_valid = 1'b1; req0_addr = 5'd4; req0_data = 32'h0; req0_size = 2'b00;
        #1;
        chk("ab_idle_ready0", {31'd0, req0_ready}, 32'd1);
        chk("ab_idle_ready1", {31'd0, req1_ready}, 32'd0);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
